ccx_ic_arbiter_n: RTL and testbench
===================================

// Module: ccx_ic_arbiter_n
//
// PURPOSE
//  N-way core complex interconnect arbiter: merges NP requestors onto one
//  responder port using the core memory bus protocol (req/gnt; rdata/err
//  valid the cycle after gnt). Supports fixed-priority or round-robin modes.
//  Locks the routed requestor until its request is granted.
//  Sits between CPU fetch/LSU/debug masters and the CCX memory responder.
//
// PARAMETERS
//  NP      4    number of requestor ports (2..16)
//  AW      39   address width
//  DW      64   data width; strobe width is DW/8
//  RW      2    rtype field width
//  RR_MODE 0    0 = fixed priority (port 0 highest), 1 = round-robin
//  STARVE  16   fixed mode: cycles a waiting port may wait before forced
//               priority; 0 disables (ignored when RR_MODE=1)
//
// PORTS
//  g_clk     in   1          clock
//  g_resetn  in   1          reset, synchronous, active-low
//  m_req     in   NP         per-requestor request
//  m_rtype   in   NP*RW      per-requestor rtype, port i at [i*RW+:RW]
//  m_addr    in   NP*AW      per-requestor address
//  m_wen     in   NP         per-requestor write enable
//  m_strb    in   NP*DW/8    per-requestor write strobes
//  m_wdata   in   NP*DW      per-requestor write data
//  m_gnt     out  NP         per-requestor grant
//  m_err     out  NP         per-requestor response error
//  m_rdata   out  DW         read data, broadcast to all requestors
//  s_req     out  1          responder request
//  s_rtype   out  RW         responder rtype
//  s_addr    out  AW         responder address
//  s_wen     out  1          responder write enable
//  s_strb    out  DW/8       responder strobes
//  s_wdata   out  DW         responder write data
//  s_gnt     in   1          responder grant
//  s_err     in   1          responder error, valid the cycle after s_gnt
//  s_rdata   in   DW         responder read data, valid the cycle after s_gnt
//
// BEHAVIOUR
//  - Reset: lock_r=0, owner_r=0, rr_ptr=0, rsp_route_r=0, wait counters=0.
//    Outputs are then: m_gnt=0, m_err=0, s_req=0.
//  - Selection (combinational, every cycle):
//    * lock_r=1: selected port is owner_r.
//    * Else RR: first requesting port searching upward from rr_ptr, wrapping.
//    * Else fixed: lowest-index port whose counter reached STARVE; if none,
//      the lowest-index requesting port.
//  - s_* fields = selected port's fields, s_req = m_req[sel].
//    No requesting port (and no lock): s_req=0 and all s_* fields are 0.
//  - m_gnt[i] = (sel==i) && m_req[i] && s_gnt. Never more than one bit high.
//  - Lock: if s_req && !s_gnt, then next cycle lock_r=1 and owner_r=sel.
//    Lock clears on the cycle the owner is granted, or when the owner drops
//    m_req (the protocol forbids dropping; behaviour is defined anyway).
//    Owner address/data must stay stable while locked.
//  - Round robin: on each grant to port p, rr_ptr <= (p+1) mod NP.
//  - Starvation (fixed mode, STARVE>0): per-port counter counts up while
//    m_req[i] && !m_gnt[i], saturating at STARVE. It clears on grant or when
//    req drops. Forced priority never pre-empts an active lock.
//  - Response routing:
//    * rsp_route_r <= one-hot(m_gnt), registered every cycle.
//    * m_err[i] = rsp_route_r[i] && s_err; m_rdata = s_rdata unconditionally.
//  - Back-to-back grants to different ports on consecutive cycles are legal.
//    Each response routes to the port granted in the prior cycle.
//  - Reset mid-transaction drops the lock and the pending response route;
//    the responder is reset in the same cycle.
//  - Latency: zero-cycle request path (comb); response path is 1 cycle.
//
// TESTING
//  1 Fixed, NP=4: m_req=4'b1010, s_gnt=1 -> m_gnt=4'b0010; next cycle
//    s_err=1 -> m_err=4'b0010.
//  2 Fixed, s_gnt held 0: port 3 alone for 1 cycle, then port 0 also
//    requests -> s_addr stays port 3 (lock); port 3 granted first, then
//    port 0.
//  3 RR, NP=4: all four request continuously, s_gnt=1 -> grant order
//    0,1,2,3,0,...; exactly one m_gnt bit high per cycle.
//  4 Fixed, STARVE=4: ports 0 and 2 request continuously, port 0
//    re-granted every cycle -> port 2 granted on 5th cycle of waiting,
//    then port 0 resumes.
//  5 Idle: m_req=0 -> s_req=0, s_addr=0, m_gnt=0; s_err=1 injected ->
//    m_err=0.
//  6 Assert g_resetn=0 while locked to port 1 -> next cycle lock_r=0,
//    m_err=0; after release, port 0 request granted normally.

Source files
------------

// File: rtl/ccx_ic_arbiter_n.sv
// ccx_ic_arbiter_n
//   Merges NP core-memory-bus requestors onto a single responder port.
//   The request path is purely combinational (zero-cycle). The response
//   (s_err) is routed back one cycle later to whichever port was granted
//   in the previous cycle. Two arbitration modes are available:
//   fixed priority, with optional starvation promotion, or round-robin.
//   A requestor that is presented to the responder but not granted is
//   locked in until it is granted or drops its request.
//
// Handshake: a requestor raises m_req[i] with its fields stable and keeps
//   them until m_gnt[i]. A transfer happens in the cycle where s_req and
//   s_gnt are both high. Read data and error follow one cycle later.
//
// Ports
//   g_clk, g_resetn     clock, synchronous active-low reset
//   m_req/m_rtype/m_addr/m_wen/m_strb/m_wdata
//                       per-requestor request fields, port i at [i*W +: W]
//   m_gnt, m_err        per-requestor grant and response error
//   m_rdata             read data, broadcast to every requestor
//   s_req/s_rtype/s_addr/s_wen/s_strb/s_wdata
//                       fields of the selected requestor
//   s_gnt, s_err, s_rdata
//                       responder grant, error and read data
module ccx_ic_arbiter_n #(
  parameter int NP      = 4,
  parameter int AW      = 39,
  parameter int DW      = 64,
  parameter int RW      = 2,
  parameter int RR_MODE = 0,
  parameter int STARVE  = 16
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic [NP-1:0]        m_req,
  input  logic [NP*RW-1:0]     m_rtype,
  input  logic [NP*AW-1:0]     m_addr,
  input  logic [NP-1:0]        m_wen,
  input  logic [NP*DW/8-1:0]   m_strb,
  input  logic [NP*DW-1:0]     m_wdata,
  output logic [NP-1:0]        m_gnt,
  output logic [NP-1:0]        m_err,
  output logic [DW-1:0]        m_rdata,
  output logic                 s_req,
  output logic [RW-1:0]        s_rtype,
  output logic [AW-1:0]        s_addr,
  output logic                 s_wen,
  output logic [DW/8-1:0]      s_strb,
  output logic [DW-1:0]        s_wdata,
  input  logic                 s_gnt,
  input  logic                 s_err,
  input  logic [DW-1:0]        s_rdata
);

  localparam int SW = $clog2(NP);
  localparam int BW = DW / 8;
  localparam int CW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam bit STARVE_EN = (RR_MODE == 0) && (STARVE > 0);

  logic          lock_q, lock_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NP-1:0] rsp_route_q;
  logic [CW-1:0] wait_q [NP];
  logic [CW-1:0] wait_d [NP];

  logic [SW-1:0] sel;
  logic          sel_vld;
  logic [NP-1:0] starved;
  logic          xfer;

  // Port selection. Loops run from the top index down so the lowest
  // qualifying candidate is the last (winning) assignment.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = 0; i < NP; i++) begin
      starved[i] = STARVE_EN && m_req[i] && (wait_q[i] == CW'(STARVE));
    end
    if (lock_q) begin
      sel     = owner_q;
      sel_vld = 1'b1;
    end else if (RR_MODE != 0) begin
      for (int k = NP - 1; k >= 0; k--) begin
        if (m_req[(int'(rr_ptr_q) + k) % NP]) begin
          sel     = SW'((int'(rr_ptr_q) + k) % NP);
          sel_vld = 1'b1;
        end
      end
    end else begin
      for (int i = NP - 1; i >= 0; i--) begin
        if (m_req[i]) begin
          sel     = SW'(i);
          sel_vld = 1'b1;
        end
      end
      // Starved ports override plain priority (never an active lock).
      if (|starved) begin
        for (int i = NP - 1; i >= 0; i--) begin
          if (starved[i]) sel = SW'(i);
        end
      end
    end
  end

  // Responder side: selected port's fields, or all zero when nothing is
  // selected.
  always_comb begin
    s_req   = 1'b0;
    s_rtype = '0;
    s_addr  = '0;
    s_wen   = 1'b0;
    s_strb  = '0;
    s_wdata = '0;
    if (sel_vld) begin
      s_req   = m_req[sel];
      s_rtype = m_rtype[int'(sel)*RW +: RW];
      s_addr  = m_addr[int'(sel)*AW +: AW];
      s_wen   = m_wen[sel];
      s_strb  = m_strb[int'(sel)*BW +: BW];
      s_wdata = m_wdata[int'(sel)*DW +: DW];
    end
  end

  assign xfer = s_req && s_gnt;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      m_gnt[i] = xfer && (sel == SW'(i));
    end
  end

  assign m_err   = rsp_route_q & {NP{s_err}};
  assign m_rdata = s_rdata;

  // Next state. An owner that is granted or drops its request makes
  // s_req/xfer such that lock_d falls naturally.
  always_comb begin
    lock_d   = s_req && !s_gnt;
    owner_d  = lock_d ? sel : owner_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (sel == SW'(NP - 1)) ? '0 : sel + SW'(1);
    end
    for (int i = 0; i < NP; i++) begin
      wait_d[i] = '0;
      if (STARVE_EN && m_req[i] && !m_gnt[i]) begin
        wait_d[i] = (wait_q[i] == CW'(STARVE)) ? wait_q[i] : wait_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lock_q      <= 1'b0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      rsp_route_q <= '0;
      for (int i = 0; i < NP; i++) wait_q[i] <= '0;
    end else begin
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_route_q <= m_gnt;
      for (int i = 0; i < NP; i++) wait_q[i] <= wait_d[i];
    end
  end

endmodule

// File: tb/tb_ccx_ic_arbiter_n.sv
// Bench for ccx_ic_arbiter_n. A fixed-priority instance (STARVE=4) and a
// round-robin instance share the same requestor/responder stimulus. A
// behavioural model per instance produces the expected outputs for each
// cycle into a queue; a monitor on the falling edge pops and compares.
module tb_ccx_ic_arbiter_n;
  localparam int NP  = 4;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int RW  = 2;
  localparam int BW  = DW / 8;
  localparam int STV = 4;
  localparam int W   = 1 + NP + NP + AW + DW + DW + BW + RW + 1;

  // clock / reset
  logic g_clk = 1'b0;
  logic g_resetn;
  always #5 g_clk = ~g_clk;

  logic [NP-1:0]    m_req;
  logic [NP*RW-1:0] m_rtype;
  logic [NP*AW-1:0] m_addr;
  logic [NP-1:0]    m_wen;
  logic [NP*BW-1:0] m_strb;
  logic [NP*DW-1:0] m_wdata;
  logic             s_gnt, s_err;
  logic [DW-1:0]    s_rdata;

  logic [NP-1:0] f_gnt, f_err, r_gnt, r_err;
  logic [DW-1:0] f_rdata, r_rdata, f_swdata, r_swdata;
  logic          f_sreq, r_sreq, f_swen, r_swen;
  logic [RW-1:0] f_srtype, r_srtype;
  logic [AW-1:0] f_saddr, r_saddr;
  logic [BW-1:0] f_sstrb, r_sstrb;

  ccx_ic_arbiter_n #(.NP(NP), .AW(AW), .DW(DW), .RW(RW), .RR_MODE(0), .STARVE(STV)) dut_fix (
    .g_clk(g_clk), .g_resetn(g_resetn), .m_req(m_req), .m_rtype(m_rtype), .m_addr(m_addr),
    .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata), .m_gnt(f_gnt), .m_err(f_err),
    .m_rdata(f_rdata), .s_req(f_sreq), .s_rtype(f_srtype), .s_addr(f_saddr), .s_wen(f_swen),
    .s_strb(f_sstrb), .s_wdata(f_swdata), .s_gnt(s_gnt), .s_err(s_err), .s_rdata(s_rdata));

  ccx_ic_arbiter_n #(.NP(NP), .AW(AW), .DW(DW), .RW(RW), .RR_MODE(1), .STARVE(STV)) dut_rr (
    .g_clk(g_clk), .g_resetn(g_resetn), .m_req(m_req), .m_rtype(m_rtype), .m_addr(m_addr),
    .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata), .m_gnt(r_gnt), .m_err(r_err),
    .m_rdata(r_rdata), .s_req(r_sreq), .s_rtype(r_srtype), .s_addr(r_saddr), .s_wen(r_swen),
    .s_strb(r_sstrb), .s_wdata(r_swdata), .s_gnt(s_gnt), .s_err(s_err), .s_rdata(s_rdata));

  // scoreboard state
  logic [W-1:0] exp_f_q[$];
  logic [W-1:0] exp_r_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // reference model state, index 0 = fixed, 1 = round-robin
  bit md_lock [2];
  int md_owner[2];
  int md_ptr  [2];
  int md_prev [2];
  int md_gnt  [2];
  int md_wait [2][NP];

  function automatic logic [W-1:0] pack(logic sreq, logic [NP-1:0] gnt, logic [NP-1:0] err,
                                        logic [AW-1:0] a, logic [DW-1:0] wd, logic [DW-1:0] rd,
                                        logic [BW-1:0] st, logic [RW-1:0] rt, logic we);
    return {sreq, gnt, err, a, wd, rd, st, rt, we};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      md_lock[m] = 1'b0; md_owner[m] = 0; md_ptr[m] = 0; md_prev[m] = -1; md_gnt[m] = -1;
      for (int i = 0; i < NP; i++) md_wait[m][i] = 0;
    end
  endtask

  // One cycle of model m: expected outputs from current inputs, then
  // advance the model state as the coming clock edge will.
  task automatic model_step(input int m, output logic [W-1:0] e);
    int sel, gp;
    logic sreq;
    logic [NP-1:0] gnt, err;
    sel = -1;
    if (md_lock[m]) sel = md_owner[m];
    else if (m == 1) begin
      for (int k = 0; k < NP; k++)
        if (sel < 0 && m_req[(md_ptr[m] + k) % NP]) sel = (md_ptr[m] + k) % NP;
    end else begin
      for (int i = 0; i < NP; i++)
        if (sel < 0 && m_req[i] && md_wait[m][i] >= STV) sel = i;
      for (int i = 0; i < NP; i++)
        if (sel < 0 && m_req[i]) sel = i;
    end
    sreq = (sel >= 0) && m_req[sel];
    gp   = (sreq && s_gnt) ? sel : -1;
    gnt  = (gp >= 0) ? NP'(1 << gp) : '0;
    err  = (md_prev[m] >= 0 && s_err) ? NP'(1 << md_prev[m]) : '0;
    if (sel >= 0)
      e = pack(sreq, gnt, err, m_addr[sel*AW +: AW], m_wdata[sel*DW +: DW], s_rdata,
               m_strb[sel*BW +: BW], m_rtype[sel*RW +: RW], m_wen[sel]);
    else
      e = pack(1'b0, gnt, err, '0, '0, s_rdata, '0, '0, 1'b0);
    md_gnt[m] = gp;
    if (!g_resetn) begin
      md_lock[m] = 1'b0; md_owner[m] = 0; md_ptr[m] = 0; md_prev[m] = -1;
      for (int i = 0; i < NP; i++) md_wait[m][i] = 0;
    end else begin
      md_prev[m] = gp;
      md_lock[m] = sreq && !s_gnt;
      if (md_lock[m]) md_owner[m] = sel;
      if (gp >= 0) md_ptr[m] = (gp + 1) % NP;
      for (int i = 0; i < NP; i++) begin
        if (m == 0 && m_req[i] && gp != i) md_wait[m][i] = (md_wait[m][i] < STV) ? md_wait[m][i] + 1 : STV;
        else md_wait[m][i] = 0;
      end
    end
  endtask

  task automatic rand_fields(input int i);
    m_rtype[i*RW +: RW] = RW'($urandom);
    m_addr [i*AW +: AW] = AW'($urandom);
    m_wen  [i]          = 1'($urandom);
    m_strb [i*BW +: BW] = BW'($urandom);
    m_wdata[i*DW +: DW] = DW'($urandom);
  endtask

  // driver: one clock cycle of stimulus; fmask selects ports whose fields
  // are refreshed; chk=0 skips expectations (state still unknown).
  task automatic cyc(input logic [NP-1:0] req, input logic sg, input logic se,
                     input logic rn, input bit chk, input logic [NP-1:0] fmask);
    logic [W-1:0] e0, e1;
    @(posedge g_clk);
    #1;
    cyc_n++;
    for (int i = 0; i < NP; i++) if (fmask[i]) rand_fields(i);
    m_req    = req;
    s_gnt    = sg;
    s_err    = se;
    g_resetn = rn;
    s_rdata  = DW'($urandom);
    model_step(0, e0);
    model_step(1, e1);
    if (chk) begin
      exp_f_q.push_back(e0);
      exp_r_q.push_back(e1);
    end
  endtask

  // monitor
  always @(negedge g_clk) begin
    logic [W-1:0] e, a;
    if (exp_f_q.size() > 0) begin
      e = exp_f_q.pop_front();
      a = pack(f_sreq, f_gnt, f_err, f_saddr, f_swdata, f_rdata, f_sstrb, f_srtype, f_swen);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL fixed_out cycle %0d got %h exp %h", cyc_n, a, e);
      end
    end
    if (exp_r_q.size() > 0) begin
      e = exp_r_q.pop_front();
      a = pack(r_sreq, r_gnt, r_err, r_saddr, r_swdata, r_rdata, r_sstrb, r_srtype, r_swen);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL rr_out cycle %0d got %h exp %h", cyc_n, a, e);
      end
    end
  end

  initial begin
    logic [NP-1:0] nreq, fm;
    m_req = '0; m_rtype = '0; m_addr = '0; m_wen = '0; m_strb = '0; m_wdata = '0;
    s_gnt = 1'b0; s_err = 1'b0; s_rdata = '0; g_resetn = 1'b0;
    model_reset();

    // reset and reset-state outputs
    cyc(4'b0000, 0, 0, 0, 0, 4'hF);
    cyc(4'b0000, 0, 1, 0, 1, 4'h0);
    cyc(4'b0000, 0, 1, 1, 1, 4'h0);
    // single grant and routed error
    cyc(4'b1010, 1, 0, 1, 1, 4'h0);
    cyc(4'b0000, 0, 1, 1, 1, 4'h0);
    // lock holds port 3 against higher-priority port 0
    cyc(4'b1000, 0, 0, 1, 1, 4'h0);
    cyc(4'b1001, 0, 0, 1, 1, 4'h0);
    cyc(4'b1001, 0, 0, 1, 1, 4'h0);
    cyc(4'b1001, 1, 0, 1, 1, 4'h0);
    cyc(4'b0001, 1, 1, 1, 1, 4'h0);
    cyc(4'b0000, 0, 1, 1, 1, 4'h0);
    // fresh reset, then all ports requesting continuously
    cyc(4'b0000, 0, 0, 0, 1, 4'h0);
    for (int n = 0; n < 9; n++) cyc(4'b1111, 1, n[0], 1, 1, 4'h0);
    // starvation promotion of port 2
    cyc(4'b0000, 0, 0, 1, 1, 4'h0);
    for (int n = 0; n < 8; n++) cyc(4'b0101, 1, 0, 1, 1, 4'h0);
    // idle with stray error
    cyc(4'b0000, 0, 0, 1, 1, 4'h0);
    cyc(4'b0000, 1, 1, 1, 1, 4'h0);
    // reset while locked to port 1, with a grant in the reset cycle
    cyc(4'b0010, 0, 0, 1, 1, 4'h0);
    cyc(4'b0010, 1, 0, 0, 1, 4'h0);
    cyc(4'b0000, 0, 1, 1, 1, 4'h0);
    cyc(4'b0001, 1, 0, 1, 1, 4'h0);
    cyc(4'b0000, 0, 1, 1, 1, 4'h0);

    // random traffic: requestors hold until granted (judged by the
    // fixed-priority model); occasional drops and resets
    for (int n = 0; n < 600; n++) begin
      nreq = '0;
      fm   = '0;
      for (int i = 0; i < NP; i++) begin
        if (m_req[i] && md_gnt[0] != i && $urandom_range(0, 19) != 0) nreq[i] = 1'b1;
        else begin
          nreq[i] = 1'($urandom_range(0, 1));
          fm[i]   = 1'b1;
        end
      end
      cyc(nreq, ($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 79) != 0), 1, fm);
    end

    cyc(4'b0000, 0, 0, 1, 1, 4'h0);
    @(negedge g_clk);
    @(negedge g_clk);
    if (exp_f_q.size() != 0 || exp_r_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain left %0d/%0d required 0", exp_f_q.size(), exp_r_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
